// File: rtl/sad_min_sel.sv
// Minimum-SAD selector: scans a SEARCH_W x SEARCH_H window in raster order and emits the
// lowest SAD and its motion vector through a one-deep valid/ready register. Option: SAD_MIN_TIE_LAST_EN.
module sad_min_sel #(
    parameter int SAD_WIDTH = 16,
    parameter int SEARCH_W  = 16,
    parameter int SEARCH_H  = 16,
    parameter int MV_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 search_start,
    input  logic                 sad_valid,
    input  logic [SAD_WIDTH-1:0] sad_in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [SAD_WIDTH-1:0] best_sad,
    output logic [MV_WIDTH-1:0]  best_mvx,
    output logic [MV_WIDTH-1:0]  best_mvy,
    output logic                 busy,
    output logic                 overflow
);

    localparam int XW = $clog2(SEARCH_W);
    localparam int YW = $clog2(SEARCH_H);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t               state;
    logic [XW-1:0]        x, run_x;
    logic [YW-1:0]        y, run_y;
    logic [SAD_WIDTH-1:0] run_sad;

    logic                 sample, first, last, better, take;
    logic [SAD_WIDTH-1:0] win_sad;
    logic [XW-1:0]        win_x;
    logic [YW-1:0]        win_y;

    function automatic logic [MV_WIDTH-1:0] to_mvx(input logic [XW-1:0] c);
        logic [31:0] t;
        t = 32'(c) - 32'(SEARCH_W / 2);
        return t[MV_WIDTH-1:0];
    endfunction

    function automatic logic [MV_WIDTH-1:0] to_mvy(input logic [YW-1:0] c);
        logic [31:0] t;
        t = 32'(c) - 32'(SEARCH_H / 2);
        return t[MV_WIDTH-1:0];
    endfunction

    always_comb begin
        sample = (state == SCAN) && sad_valid && !search_start;
        first  = (x == '0) && (y == '0);
        last   = (x == '1) && (y == '1);
`ifdef SAD_MIN_TIE_LAST_EN
        better = (sad_in <= run_sad);
`else
        better = (sad_in < run_sad);
`endif
        take    = first || better;
        win_sad = take ? sad_in : run_sad;
        win_x   = take ? x : run_x;
        win_y   = take ? y : run_y;
    end

    assign busy = (state == SCAN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            run_x     <= '0;
            run_y     <= '0;
            run_sad   <= '0;
            out_valid <= 1'b0;
            best_sad  <= '0;
            best_mvx  <= '0;
            best_mvy  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (search_start) begin
                state   <= SCAN;
                x       <= '0;
                y       <= '0;
                run_sad <= '1;
            end else if (sample) begin
                if (take) begin
                    run_sad <= sad_in;
                    run_x   <= x;
                    run_y   <= y;
                end
                x <= x + XW'(1);
                if (x == '1)
                    y <= y + YW'(1);
                if (last) begin
                    state <= IDLE;
                    // A result taken this same cycle frees the register for the new one.
                    if (!out_valid || out_ready) begin
                        best_sad  <= win_sad;
                        best_mvx  <= to_mvx(win_x);
                        best_mvy  <= to_mvy(win_y);
                        out_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_min_sel.sv
// Scoreboard bench for sad_min_sel: a reference model picks the minimum over each search's
// sample array; a negedge monitor compares every handshake and the status outputs.
module tb_sad_min_sel;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        search_start = 1'b0;
    logic        sad_valid = 1'b0;
    logic [15:0] sad_in = '0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [15:0] best_sad;
    logic [4:0]  best_mvx, best_mvy;
    logic        busy, overflow;

    sad_min_sel #(.SAD_WIDTH(16), .SEARCH_W(16), .SEARCH_H(16), .MV_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .search_start(search_start), .sad_valid(sad_valid),
        .sad_in(sad_in), .out_ready(out_ready), .out_valid(out_valid), .best_sad(best_sad),
        .best_mvx(best_mvx), .best_mvy(best_mvy), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sad;
        logic [4:0]  mx;
        logic [4:0]  my;
    } res_t;

    res_t        q[$];
    logic [15:0] sads[256];
    bit          exp_busy = 0;
    bit          exp_ovf = 0;
    bit          mon_en = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: first element always seeds the minimum, then raster-order scan with the tie rule.
    function automatic res_t model();
        res_t r;
        int   bi = 0;
        for (int i = 1; i < 256; i++) begin
`ifdef SAD_MIN_TIE_LAST_EN
            if (sads[i] <= sads[bi]) bi = i;
`else
            if (sads[i] < sads[bi]) bi = i;
`endif
        end
        r.sad = sads[bi];
        r.mx  = 5'((bi % 16) - 8);
        r.my  = 5'((bi / 16) - 8);
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            if (out_valid && out_ready && q.size() != 0) begin
                res_t r;
                r = q.pop_front();
                chk("best_sad", 32'(best_sad), 32'(r.sad));
                chk("best_mvx", 32'(best_mvx), 32'(r.mx));
                chk("best_mvy", 32'(best_mvy), 32'(r.my));
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst best_sad", 32'(best_sad), 0);
        chk("rst best_mvx", 32'(best_mvx), 0);
        chk("rst best_mvy", 32'(best_mvy), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst overflow", 32'(overflow), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sad_valid = 1'($urandom);
            sad_in    = 16'($urandom);
            @(posedge clk); #1;
        end
        sad_valid = 1'b0;
    endtask

    // n: samples to drive; gap_pct: chance of a sad_valid-low cycle; rst_at: sample index of a reset pulse
    task automatic run_search(input int n, input int gap_pct, input int rst_at, input bit rnd_ready);
        bit dead = 0;
        bit drop;
        search_start = 1'b1;
        sad_valid    = 1'($urandom);
        sad_in       = 16'($urandom);
        if (rnd_ready) out_ready = 1'($urandom);
        @(posedge clk); #1;
        search_start = 1'b0;
        exp_busy     = 1;
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                sad_valid = 1'b0;
                sad_in    = 16'($urandom);
                if (rnd_ready) out_ready = 1'($urandom);
                @(posedge clk); #1;
            end
            sad_valid = 1'b1;
            sad_in    = sads[i];
            if (rnd_ready) out_ready = 1'($urandom);
            if (i == rst_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                q.delete();
                exp_ovf  = 0;
                exp_busy = 0;
                dead     = 1;
                check_reset_outputs();
            end else begin
                drop = (q.size() != 0) && !out_ready;
                @(posedge clk); #1;
                if (i == 255 && !dead) begin
                    exp_busy = 0;
                    if (drop) exp_ovf = 1;
                    else q.push_back(model());
                end
            end
        end
        sad_valid = 1'b0;
    endtask

    task automatic fill_random(input int lo);
        for (int i = 0; i < 256; i++) sads[i] = 16'($urandom_range(lo, 65535));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs();
        mon_en = 1;

        // Single minimum at (11,3)
        for (int i = 0; i < 256; i++) sads[i] = 16'd1000;
        sads[3 * 16 + 11] = 16'd17;
        run_search(256, 0, -1, 0);
        idle(3);

        // All ties
        for (int i = 0; i < 256; i++) sads[i] = 16'd42;
        run_search(256, 0, -1, 0);
        idle(3);

        // Gapped samples, zero at (8,8)
        fill_random(1);
        sads[8 * 16 + 8] = 16'd0;
        run_search(256, 30, -1, 0);
        idle(3);

        // Back-to-back with out_ready low: second result dropped
        out_ready = 1'b0;
        fill_random(0);
        run_search(256, 0, -1, 0);
        fill_random(0);
        run_search(256, 0, -1, 0);
        idle(3);
        out_ready = 1'b1;
        idle(3);

        // Abort after 100 samples, then full search with minimum 5 at (0,0)
        fill_random(6);
        run_search(100, 0, -1, 0);
        sads[0] = 16'd5;
        run_search(256, 0, -1, 0);
        idle(3);

        // Reset at sample 200; remaining samples produce nothing
        fill_random(0);
        run_search(256, 0, 200, 0);
        idle(3);

        // Random searches with random handshaking and back-to-back starts
        for (int k = 0; k < 6; k++) begin
            fill_random(0);
            if (k % 2 == 0) sads[$urandom_range(0, 255)] = sads[$urandom_range(0, 255)];
            if (k == 3) for (int i = 0; i < 256; i++) sads[i] = 16'($urandom_range(0, 3));
            run_search(256, (k % 3) * 10, -1, 1);
            if (k % 2 == 1) idle(2);
        end

        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
        chk("drain", 32'(q.size()), 0);
        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
